// File: rtl/speed_change_pkg.sv
// Shared types and the symmetric saturation helper for the speed-change sequencer.
package speed_change_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        INC  = 2'b01,
        DEC  = 2'b10,
        RSVD = 2'b11
    } speed_dir_t;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE
    } seq_state_t;

    // Clips v to +/-(2^(w-1) - 1) so the counter range stays symmetric.
    function automatic logic signed [31:0] sat_sym(input logic signed [31:0] v, input int w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; done_o marks the last cycle of a loaded interval.
module pulse_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/speed_change_sequencer.sv
// Nets speed-change requests and issues timed FINC/FDEC pulses with a settle gap.
// Define SPEED_CHANGE_STATS_EN to build the inc_total/dec_total pulse counters.
module speed_change_sequencer
    import speed_change_pkg::*;
#(
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 1000,
    parameter int PEND_W        = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    input  logic [1:0]               req_dir_i,
    input  logic                     hold_i,
    output logic                     finc_o,
    output logic                     fdec_o,
    output logic                     busy_o,
    output logic signed [PEND_W-1:0] pending_o,
    output logic                     overflow_o,
    output logic [15:0]              inc_total_o,
    output logic [15:0]              dec_total_o
);

    localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    localparam int SW   = PEND_W + 2;

    seq_state_t               state_q, state_d;
    speed_dir_t               dir_q, dir_d;
    logic signed [PEND_W-1:0] pending_q, pending_d;
    logic                     finc_q, fdec_q, busy_q, ovf_q;
    logic                     tmr_load, tmr_done;
    logic [TW-1:0]            tmr_val;
    logic                     launch_inc, launch_dec, clip;
    logic signed [SW-1:0]     delta_req, delta_issue, sum_w;
    logic signed [31:0]       sat_w;

    pulse_timer #(.W(TW)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        launch_inc = 1'b0;
        launch_dec = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hold_i && pending_q != '0) begin
                    launch_inc = !pending_q[PEND_W-1];
                    launch_dec = pending_q[PEND_W-1];
                    dir_d      = pending_q[PEND_W-1] ? DEC : INC;
                    state_d    = PULSE;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(PULSE_CYCLES);
                end
            end
            PULSE: begin
                if (tmr_done) begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SETTLE_CYCLES);
                end
            end
            SETTLE: begin
                if (tmr_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request and launch are netted in one wide sum, then clipped once.
    always_comb begin
        delta_req = '0;
        if (req_valid_i) begin
            case (speed_dir_t'(req_dir_i))
                INC:     delta_req = SW'(1);
                DEC:     delta_req = SW'(-1);
                default: delta_req = '0;
            endcase
        end
        delta_issue = launch_inc ? SW'(1) : (launch_dec ? SW'(-1) : '0);
        sum_w       = SW'(pending_q) + delta_req - delta_issue;
        sat_w       = sat_sym(32'(sum_w), PEND_W);
        clip        = (sat_w != 32'(sum_w));
        pending_d   = PEND_W'(sat_w);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            dir_q     <= NONE;
            pending_q <= '0;
            finc_q    <= 1'b0;
            fdec_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            finc_q    <= (state_d == PULSE) && (dir_d == INC);
            fdec_q    <= (state_d == PULSE) && (dir_d == DEC);
            busy_q    <= (state_d != IDLE);
            ovf_q     <= ovf_q | clip;
        end
    end

`ifdef SPEED_CHANGE_STATS_EN
    logic [15:0] inc_total_q, dec_total_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inc_total_q <= '0;
            dec_total_q <= '0;
        end else begin
            if (launch_inc) inc_total_q <= inc_total_q + 16'd1;
            if (launch_dec) dec_total_q <= dec_total_q + 16'd1;
        end
    end

    assign inc_total_o = inc_total_q;
    assign dec_total_o = dec_total_q;
`else
    assign inc_total_o = '0;
    assign dec_total_o = '0;
`endif

    assign finc_o     = finc_q;
    assign fdec_o     = fdec_q;
    assign busy_o     = busy_q;
    assign pending_o  = pending_q;
    assign overflow_o = ovf_q;

endmodule
